tdm_demultiplexer_1x4: RTL



---
 rtl/tdm_pkg.sv | 21 ++
 rtl/tdm_channel_counter.sv | 52 +++++
 rtl/tdm_demultiplexer_1x4.sv | 136 +++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM demultiplexer.
//   tdm_state_e : sync-hunt state, 1-bit encoding
//   ch_width()  : channel-index width, never less than one bit
//   N_CH_DEFAULT / W_DEFAULT : default channel count and sample width
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

    localparam int N_CH_DEFAULT = 4;
    localparam int W_DEFAULT    = 1;

    function automatic int ch_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tdm_channel_counter.sv
// Mod-N_CH channel index counter for the TDM demultiplexer.
// Ports:
//   clk_i    rising-edge clock
//   rst_i    synchronous reset, active-high (counter -> 0)
//   en_i     advance by one, wrapping N_CH-1 -> 0
//   load1_i  force the count to 1 (channel 0 just accepted)
//   clr_i    force the count to 0
//   cnt_o    current channel index (next expected channel)
//   last_o   high while the count equals N_CH-1
module tdm_channel_counter
    import tdm_pkg::*;
#(
    parameter int N_CH = N_CH_DEFAULT,
    parameter int CH_W = ch_width(N_CH)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic            load1_i,
    input  logic            clr_i,
    output logic [CH_W-1:0] cnt_o,
    output logic            last_o
);

    localparam logic [CH_W-1:0] LAST = CH_W'(N_CH - 1);

    logic [CH_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load1_i) begin
            cnt_d = CH_W'(1);
        end else if (en_i) begin
            // explicit wrap so non-power-of-two channel counts work
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == LAST);

endmodule

// File: rtl/tdm_demultiplexer_1x4.sv
// TDM demultiplexer: serial sample stream in, N_CH parallel channel outputs.
// Hunts for frame sync, steers each valid sample to its channel slot and
// publishes complete frames; sync faults set a sticky error flag.
// Ports:
//   CLK  rising-edge clock
//   RST  synchronous reset, active-high
//   D    sample data (W bits), sampled when V=1
//   V    sample valid
//   F    frame sync, high with the channel-0 sample
//   Y    channel outputs, channel i at Y[i*W +: W]
//   S    next expected channel index
//   U    one-cycle frame-update pulse
//   E    sticky sync-error flag (cleared only by RST)
// Build option:
//   TDM_LIVE_UPDATE_EN defined   -> samples written straight into Y slots
//   TDM_LIVE_UPDATE_EN undefined -> frame-coherent double buffering (default)
//
// state  | meaning
// HUNT   | waiting for a sync-marked sample; unsynced samples dropped
// LOCKED | in frame alignment; S tracks the next channel expected
module tdm_demultiplexer_1x4
    import tdm_pkg::*;
#(
    parameter int N_CH = N_CH_DEFAULT,
    parameter int W    = W_DEFAULT,
    localparam int CH_W = ch_width(N_CH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [W-1:0]      D,
    input  logic              V,
    input  logic              F,
    output logic [N_CH*W-1:0] Y,
    output logic [CH_W-1:0]   S,
    output logic              U,
    output logic              E
);

    tdm_state_e        state_q, state_d;
    logic [N_CH*W-1:0] y_q, y_d;
    logic              u_q, u_d;
    logic              e_q, e_d;
`ifndef TDM_LIVE_UPDATE_EN
    // channel N_CH-1 never needs a shadow slot: it goes straight into Y
    logic [(N_CH-1)*W-1:0] shadow_q, shadow_d;
`endif

    logic [CH_W-1:0] cnt;
    logic            cnt_last, cnt_en, cnt_load1, cnt_clr;

    tdm_channel_counter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_cnt (
        .clk_i   (CLK),
        .rst_i   (RST),
        .en_i    (cnt_en),
        .load1_i (cnt_load1),
        .clr_i   (cnt_clr),
        .cnt_o   (cnt),
        .last_o  (cnt_last)
    );

    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        e_d       = e_q;
        u_d       = 1'b0;
        cnt_en    = 1'b0;
        cnt_load1 = 1'b0;
        cnt_clr   = 1'b0;
`ifndef TDM_LIVE_UPDATE_EN
        shadow_d  = shadow_q;
`endif
        if (V) begin
            if (F) begin
                // sync always (re)starts a frame; mid-frame sync is a fault
                if (state_q == LOCKED && cnt != '0) begin
                    e_d = 1'b1;
                end
                state_d   = LOCKED;
                cnt_load1 = 1'b1;
`ifdef TDM_LIVE_UPDATE_EN
                y_d[0 +: W] = D;
`else
                shadow_d[0 +: W] = D;
`endif
            end else if (state_q == LOCKED) begin
                if (cnt == '0) begin
                    // expected a sync here: drop sample and re-hunt
                    e_d     = 1'b1;
                    state_d = HUNT;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                    u_d    = cnt_last;
`ifdef TDM_LIVE_UPDATE_EN
                    y_d[cnt*W +: W] = D;
`else
                    if (cnt_last) begin
                        y_d = {D, shadow_q};
                    end else begin
                        shadow_d[cnt*W +: W] = D;
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= HUNT;
            y_q      <= '0;
            u_q      <= 1'b0;
            e_q      <= 1'b0;
`ifndef TDM_LIVE_UPDATE_EN
            shadow_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            u_q      <= u_d;
            e_q      <= e_d;
`ifndef TDM_LIVE_UPDATE_EN
            shadow_q <= shadow_d;
`endif
        end
    end

    assign Y = y_q;
    assign S = cnt;
    assign U = u_q;
    assign E = e_q;

endmodule
